// File: rtl/jtexterm_rom_arb.sv
// Read-only SDRAM bank arbiter for main CPU, sub CPU and gfx ROM ports; packs 16-bit words into 8/32-bit results.
// Optional JTEXTERM_ROUNDROBIN_EN selects round-robin grant instead of fixed gfx > main > sub priority.
module jtexterm_rom_arb #(
  parameter int          MAIN_AW     = 17,
  parameter int          SUB_AW      = 16,
  parameter int          GFX_AW      = 20,
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] SUB_OFFSET  = 22'h10000,
  parameter logic [21:0] GFX_OFFSET  = 22'h20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic              main_cs,
  input  logic [MAIN_AW-1:0] main_addr,
  output logic [7:0]        main_data,
  output logic              main_ok,
  input  logic              sub_cs,
  input  logic [SUB_AW-1:0] sub_addr,
  output logic [7:0]        sub_data,
  output logic              sub_ok,
  input  logic              gfx_cs,
  input  logic [GFX_AW-1:0] gfx_addr,
  output logic [31:0]       gfx_data,
  output logic              gfx_ok,
  output logic [21:0]       ba_addr,
  output logic              ba_rd,
  input  logic              ba_ack,
  input  logic              ba_dok,
  input  logic              ba_rdy,
  input  logic [15:0]       data_read
);
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;
  localparam logic [1:0] G_MAIN = 2'd0, G_SUB = 2'd1, G_GFX = 2'd2;

  state_t             state_q;
  logic [1:0]         sel_q;
  logic               first_q;
  logic               ba_rd_q;
  logic [21:0]        ba_addr_q;
  logic [MAIN_AW-1:0] main_addr_q;
  logic [SUB_AW-1:0]  sub_addr_q;
  logic [GFX_AW-1:0]  gfx_addr_q;
  logic [7:0]         main_data_q, sub_data_q;
  logic [31:0]        gfx_data_q;
  logic               main_vld_q, sub_vld_q, gfx_vld_q;

  logic        main_hit, sub_hit, gfx_hit;
  logic [2:0]  pend;
  logic        gnt_any, grant_go;
  logic [1:0]  gnt_sel;
  logic [21:0] gnt_wa;

  assign main_hit = main_vld_q && (main_addr_q == main_addr);
  assign sub_hit  = sub_vld_q  && (sub_addr_q  == sub_addr);
  assign gfx_hit  = gfx_vld_q  && (gfx_addr_q  == gfx_addr);
  assign main_ok  = main_cs && main_hit;
  assign sub_ok   = sub_cs  && sub_hit;
  assign gfx_ok   = gfx_cs  && gfx_hit;
  assign pend     = {gfx_cs && !gfx_hit, sub_cs && !sub_hit, main_cs && !main_hit};
  assign gnt_any  = |pend;
  assign grant_go = (state_q == ST_IDLE) && gnt_any && !downloading;

  assign main_data = main_data_q;
  assign sub_data  = sub_data_q;
  assign gfx_data  = gfx_data_q;
  assign ba_rd     = ba_rd_q;
  assign ba_addr   = ba_addr_q;

`ifdef JTEXTERM_ROUNDROBIN_EN
  logic [1:0] last_q;

  // Search starts just after the last granted requester.
  always_comb begin
    case (last_q)
      G_MAIN:  gnt_sel = pend[1] ? G_SUB  : (pend[2] ? G_GFX  : G_MAIN);
      G_SUB:   gnt_sel = pend[2] ? G_GFX  : (pend[0] ? G_MAIN : G_SUB);
      default: gnt_sel = pend[0] ? G_MAIN : (pend[1] ? G_SUB  : G_GFX);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           last_q <= G_GFX;
    else if (grant_go) last_q <= gnt_sel;
  end
`else
  always_comb begin
    gnt_sel = pend[2] ? G_GFX : (pend[0] ? G_MAIN : G_SUB);
  end
`endif

  always_comb begin
    case (gnt_sel)
      G_MAIN:  gnt_wa = 22'(main_addr[MAIN_AW-1:1]) + MAIN_OFFSET;
      G_SUB:   gnt_wa = 22'(sub_addr[SUB_AW-1:1]) + SUB_OFFSET;
      default: gnt_wa = 22'({gfx_addr, 1'b0}) + GFX_OFFSET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= G_MAIN;
      first_q     <= 1'b0;
      ba_rd_q     <= 1'b0;
      ba_addr_q   <= '0;
      main_addr_q <= '0;
      sub_addr_q  <= '0;
      gfx_addr_q  <= '0;
      main_data_q <= '0;
      sub_data_q  <= '0;
      gfx_data_q  <= '0;
      main_vld_q  <= 1'b0;
      sub_vld_q   <= 1'b0;
      gfx_vld_q   <= 1'b0;
    end else begin
      if (downloading) begin
        main_vld_q <= 1'b0;
        sub_vld_q  <= 1'b0;
        gfx_vld_q  <= 1'b0;
      end
      case (state_q)
        ST_IDLE: if (grant_go) begin
          state_q   <= ST_REQ;
          ba_rd_q   <= 1'b1;
          ba_addr_q <= gnt_wa;
          sel_q     <= gnt_sel;
          first_q   <= 1'b1;
          // The grant-time address is what gets stored; the old result is dropped now.
          case (gnt_sel)
            G_MAIN:  begin main_addr_q <= main_addr; main_vld_q <= 1'b0; end
            G_SUB:   begin sub_addr_q  <= sub_addr;  sub_vld_q  <= 1'b0; end
            default: begin gfx_addr_q  <= gfx_addr;  gfx_vld_q  <= 1'b0; end
          endcase
        end
        ST_REQ: if (ba_ack) begin
          ba_rd_q <= 1'b0;
          state_q <= ST_DATA;
        end
        default: begin
          if (ba_dok) begin
            first_q <= 1'b0;
            case (sel_q)
              G_MAIN:  if (first_q) main_data_q <= main_addr_q[0] ? data_read[15:8] : data_read[7:0];
              G_SUB:   if (first_q) sub_data_q  <= sub_addr_q[0]  ? data_read[15:8] : data_read[7:0];
              default: if (first_q) gfx_data_q[15:0] <= data_read;
                       else         gfx_data_q[31:16] <= data_read;
            endcase
          end
          if (ba_rdy) begin
            state_q <= ST_IDLE;
            case (sel_q)
              G_MAIN:  main_vld_q <= !downloading;
              G_SUB:   sub_vld_q  <= !downloading;
              default: gfx_vld_q  <= !downloading;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtexterm_rom_arb.sv
// Directed self-checking bench for jtexterm_rom_arb; honours JTEXTERM_ROUNDROBIN_EN for the contention order.
module tb_jtexterm_rom_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        main_cs = 1'b0, sub_cs = 1'b0, gfx_cs = 1'b0;
  logic [16:0] main_addr = '0;
  logic [15:0] sub_addr = '0;
  logic [19:0] gfx_addr = '0;
  logic [7:0]  main_data, sub_data;
  logic [31:0] gfx_data;
  logic        main_ok, sub_ok, gfx_ok;
  logic [21:0] ba_addr;
  logic        ba_rd;
  logic        ba_ack = 1'b0, ba_dok = 1'b0, ba_rdy = 1'b0;
  logic [15:0] data_read = '0;

  int tests = 0;
  int fails = 0;

  jtexterm_rom_arb dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
    .sub_cs(sub_cs), .sub_addr(sub_addr), .sub_data(sub_data), .sub_ok(sub_ok),
    .gfx_cs(gfx_cs), .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_ok(gfx_ok),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dok(ba_dok),
    .ba_rdy(ba_rdy), .data_read(data_read)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; downloading = 1'b0;
    main_cs = 1'b0; sub_cs = 1'b0; gfx_cs = 1'b0;
    ba_ack = 1'b0; ba_dok = 1'b0; ba_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // SDRAM model: waits for ba_rd, acks, then returns nw words with rdy on the last.
  task automatic serve(input int nw, input logic [15:0] w0, input logic [15:0] w1,
                       output logic [21:0] got, output int lat, output bit to);
    to = 1'b1; lat = 0; got = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ba_rd === 1'b1) begin to = 1'b0; lat = i; break; end
    end
    if (!to) begin
      got = ba_addr;
      ba_ack = 1'b1;
      step();
      ba_ack = 1'b0; ba_dok = 1'b1; data_read = w0; ba_rdy = (nw == 1);
      step();
      if (nw == 2) begin
        data_read = w1; ba_rdy = 1'b1;
        step();
      end
      ba_dok = 1'b0; ba_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit to;
    do_reset();
    tests++; if (ba_rd !== 1'b0 || ba_addr !== 22'h0) begin fails++; $display("FAIL reset_ba got rd=%b addr=%h exp rd=0 addr=0", ba_rd, ba_addr); end
    tests++; if ({main_ok, sub_ok, gfx_ok} !== 3'b000 || main_data !== 8'h0 || sub_data !== 8'h0 || gfx_data !== 32'h0) begin
      fails++; $display("FAIL reset_out got ok=%b md=%h sd=%h gd=%h exp all 0", {main_ok, sub_ok, gfx_ok}, main_data, sub_data, gfx_data); end
    main_cs = 1'b1; main_addr = 17'h00005;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (ba_rd === 1'b1) begin to = 1'b0; break; end end
    tests++; if (to) begin fails++; $display("FAIL reset_req_timeout got no ba_rd exp ba_rd=1"); end
    rst = 1'b1;
    step();
    tests++; if (ba_rd !== 1'b0 || main_ok !== 1'b0) begin fails++; $display("FAIL reset_midreq got rd=%b ok=%b exp 0 0", ba_rd, main_ok); end
    rst = 1'b0; main_cs = 1'b0;
    ba_ack = 1'b1; step();
    ba_ack = 1'b0; ba_dok = 1'b1; ba_rdy = 1'b1; data_read = 16'hFFFF; step();
    ba_dok = 1'b0; ba_rdy = 1'b0; main_cs = 1'b1;
    #1;
    tests++; if (main_ok !== 1'b0 || main_data !== 8'h00) begin fails++; $display("FAIL reset_late_ack got ok=%b data=%h exp 0 00", main_ok, main_data); end
  endtask

  task automatic test_main_byte();
    logic [21:0] got; int lat; bit to;
    do_reset();
    main_cs = 1'b1; main_addr = 17'h00005;
    serve(1, 16'hA55A, 16'h0000, got, lat, to);
    tests++; if (to || got !== 22'h00002 || lat != 1) begin fails++; $display("FAIL main_req got to=%b addr=%h lat=%0d exp addr=000002 lat=1", to, got, lat); end
    tests++; if (main_ok !== 1'b1 || main_data !== 8'hA5) begin fails++; $display("FAIL main_data got ok=%b data=%h exp 1 a5", main_ok, main_data); end
    main_addr = 17'h00004;
    #1;
    tests++; if (main_ok !== 1'b0) begin fails++; $display("FAIL main_addr_change got ok=%b exp 0", main_ok); end
    serve(1, 16'hBEEF, 16'h0000, got, lat, to);
    tests++; if (to || got !== 22'h00002 || main_ok !== 1'b1 || main_data !== 8'hEF) begin
      fails++; $display("FAIL main_refetch got to=%b addr=%h ok=%b data=%h exp 000002 1 ef", to, got, main_ok, main_data); end
  endtask

  task automatic test_gfx_burst();
    logic [21:0] got; int lat; bit to;
    do_reset();
    gfx_cs = 1'b1; gfx_addr = 20'h00010;
    serve(2, 16'h1234, 16'h5678, got, lat, to);
    tests++; if (to || got !== 22'h20020) begin fails++; $display("FAIL gfx_addr got to=%b addr=%h exp 020020", to, got); end
    tests++; if (gfx_ok !== 1'b1 || gfx_data !== 32'h56781234) begin fails++; $display("FAIL gfx_data got ok=%b data=%h exp 1 56781234", gfx_ok, gfx_data); end
  endtask

  task automatic test_contention();
    logic [21:0] got [3];
    logic [21:0] exp_a [3];
    int lat [3]; bit to [3];
    do_reset();
    main_cs = 1'b1; main_addr = 17'h00002;
    sub_cs  = 1'b1; sub_addr  = 16'h0003;
    gfx_cs  = 1'b1; gfx_addr  = 20'h00001;
`ifdef JTEXTERM_ROUNDROBIN_EN
    exp_a[0] = 22'h00001; exp_a[1] = 22'h10001; exp_a[2] = 22'h20002;
`else
    exp_a[0] = 22'h20002; exp_a[1] = 22'h00001; exp_a[2] = 22'h10001;
`endif
    for (int k = 0; k < 3; k++) serve(2, 16'h9A3C, 16'h7E11, got[k], lat[k], to[k]);
    for (int k = 0; k < 3; k++) begin
      tests++; if (to[k] || got[k] !== exp_a[k]) begin fails++; $display("FAIL contention_grant%0d got to=%b addr=%h exp %h", k, to[k], got[k], exp_a[k]); end
    end
    tests++; if (lat[1] != 1 || lat[2] != 1) begin fails++; $display("FAIL back_to_back got lat=%0d,%0d exp 1,1", lat[1], lat[2]); end
    tests++; if ({main_ok, sub_ok, gfx_ok} !== 3'b111 || main_data !== 8'h3C || sub_data !== 8'h9A || gfx_data !== 32'h7E119A3C) begin
      fails++; $display("FAIL contention_data got ok=%b md=%h sd=%h gd=%h exp 111 3c 9a 7e119a3c", {main_ok, sub_ok, gfx_ok}, main_data, sub_data, gfx_data); end
  endtask

  task automatic test_addr_change();
    logic [21:0] got; int lat; bit to;
    do_reset();
    sub_cs = 1'b1; sub_addr = 16'h0008;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (ba_rd === 1'b1) begin to = 1'b0; break; end end
    tests++; if (to || ba_addr !== 22'h10004) begin fails++; $display("FAIL sub_req got to=%b addr=%h exp 010004", to, ba_addr); end
    ba_ack = 1'b1; step();
    ba_ack = 1'b0; sub_addr = 16'h000A; step();
    ba_dok = 1'b1; ba_rdy = 1'b1; data_read = 16'h4D2B; step();
    ba_dok = 1'b0; ba_rdy = 1'b0;
    tests++; if (sub_ok !== 1'b0) begin fails++; $display("FAIL sub_stale_ok got %b exp 0", sub_ok); end
    serve(1, 16'h6E71, 16'h0000, got, lat, to);
    tests++; if (to || got !== 22'h10005 || sub_ok !== 1'b1 || sub_data !== 8'h71) begin
      fails++; $display("FAIL sub_refetch got to=%b addr=%h ok=%b data=%h exp 010005 1 71", to, got, sub_ok, sub_data); end
  endtask

  task automatic test_download();
    logic [21:0] got; int lat; bit to; bit bad;
    do_reset();
    main_cs = 1'b1; main_addr = 17'h00006;
    serve(1, 16'h0102, 16'h0000, got, lat, to);
    tests++; if (to || main_ok !== 1'b1 || main_data !== 8'h02) begin fails++; $display("FAIL dl_prefetch got to=%b ok=%b data=%h exp 1 02", to, main_ok, main_data); end
    downloading = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (main_ok !== 1'b0 || ba_rd !== 1'b0) bad = 1'b1; end
    tests++; if (bad) begin fails++; $display("FAIL dl_hold got ok=%b rd=%b exp ok=0 rd=0 throughout", main_ok, ba_rd); end
    downloading = 1'b0;
    serve(1, 16'hB1C2, 16'h0000, got, lat, to);
    tests++; if (to || got !== 22'h00003 || main_ok !== 1'b1 || main_data !== 8'hC2) begin
      fails++; $display("FAIL dl_refetch got to=%b addr=%h ok=%b data=%h exp 000003 1 c2", to, got, main_ok, main_data); end
  endtask

  initial begin
    test_reset();
    test_main_byte();
    test_gfx_burst();
    test_contention();
    test_addr_change();
    test_download();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
